// File: rtl/watch_pkg.sv
// Shared weekday types, display letter codes and day/letter helper functions
// for the watch controller.
package watch_pkg;

    typedef enum logic [2:0] {MON, TUE, WED, THU, FRI, SAT, SUN} day_t;
    typedef enum logic {RUN, EDIT} mode_t;
    typedef logic [3:0][3:0] letters_t;

    localparam int DAYS = 7;

    localparam logic [3:0] C_SPACE = 4'd0;
    localparam logic [3:0] C_A     = 4'd1;
    localparam logic [3:0] C_D     = 4'd2;
    localparam logic [3:0] C_E     = 4'd3;
    localparam logic [3:0] C_F     = 4'd4;
    localparam logic [3:0] C_H     = 4'd5;
    localparam logic [3:0] C_I     = 4'd6;
    localparam logic [3:0] C_N     = 4'd7;
    localparam logic [3:0] C_O     = 4'd8;
    localparam logic [3:0] C_P     = 4'd9;
    localparam logic [3:0] C_R     = 4'd10;
    localparam logic [3:0] C_S     = 4'd11;
    localparam logic [3:0] C_T     = 4'd12;
    localparam logic [3:0] C_U     = 4'd13;
    localparam logic [3:0] C_M     = 4'd14;
    localparam logic [3:0] C_W     = 4'd15;

    // Element [3] is the leftmost display position.
    function automatic letters_t day_letters(input day_t d);
        case (d)
            MON:     return {C_M, C_O, C_N, C_SPACE};
            TUE:     return {C_T, C_U, C_E, C_SPACE};
            WED:     return {C_W, C_E, C_D, C_SPACE};
            THU:     return {C_T, C_H, C_U, C_SPACE};
            FRI:     return {C_F, C_R, C_I, C_SPACE};
            SAT:     return {C_S, C_A, C_T, C_SPACE};
            SUN:     return {C_S, C_U, C_N, C_SPACE};
            default: return {C_SPACE, C_SPACE, C_SPACE, C_SPACE};
        endcase
    endfunction

    function automatic day_t day_inc(input day_t d);
        return (d == SUN) ? MON : day_t'(d + 3'd1);
    endfunction

    function automatic day_t day_dec(input day_t d);
        return (d == MON) ? SUN : day_t'(d - 3'd1);
    endfunction

endpackage

// File: rtl/weekday_ctrl_btn_repeat.sv
// Step-pulse generator for one button: a pulse on the press, then auto-repeat.
// Step is combinational from registered state and the current button level.
module btn_repeat #(
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic btn,
    output logic step
);

    localparam int CMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DLY);
    localparam logic [CW-1:0] PER_C = CW'(REPEAT_PER);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic          btn_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] target;

    // cnt_q == 0 means idle: a button still held after clr stays silent until released.
    always_comb begin
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        step   = 1'b0;
        target = rep_q ? PER_C : DLY_C;
        if (clr || !btn) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!btn_q) begin
            step  = 1'b1;
            cnt_d = ONE_C;
            rep_d = 1'b0;
        end else if (cnt_q != '0) begin
            if (cnt_q == target) begin
                step  = 1'b1;
                cnt_d = ONE_C;
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= 1'b0;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            btn_q <= btn;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/weekday_ctrl.sv
// Weekday register with RUN/EDIT mode, auto-repeat stepping and 4-letter display codes.
// All outputs registered (one-edge latency); WEEKDAY_BLINK_EN adds the EDIT-mode blink.
module weekday_ctrl
    import watch_pkg::*;
#(
    parameter int START_DAY  = 0,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       day_tick,
    input  logic       load_en,
    input  logic [2:0] load_day,
    output logic [2:0] cur_day,
    output logic       edit_mode,
    output logic [3:0] letter0,
    output logic [3:0] letter1,
    output logic [3:0] letter2,
    output logic [3:0] letter3
);

    localparam day_t RST_DAY = day_t'(3'(START_DAY));

    if (REPEAT_DLY < 2 || REPEAT_PER < 1 || BLINK_HALF < 1 || START_DAY > 6) begin : g_bad_param
        $error("weekday_ctrl: illegal parameter value");
    end

    mode_t    mode_q, mode_d;
    day_t     day_q, day_d;
    logic     pend_q, pend_d;
    logic     start_q;
    letters_t letters_q, letters_d;
    logic     toggle, clr, load_ok, step_up, step_dn;

    assign toggle  = start && !start_q;
    assign clr     = toggle || (mode_q == RUN);
    assign load_ok = load_en && (int'(load_day) < DAYS);

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up (
        .clk(clk), .reset_n(reset_n), .clr(clr), .btn(up), .step(step_up)
    );

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dn (
        .clk(clk), .reset_n(reset_n), .clr(clr), .btn(down), .step(step_dn)
    );

    always_comb begin
        mode_d = mode_q;
        day_d  = day_q;
        pend_d = pend_q;
        if (toggle) begin
            mode_d = (mode_q == RUN) ? EDIT : RUN;
        end
        if (load_ok) begin
            day_d  = day_t'(load_day);
            pend_d = 1'b0;
        end else if (mode_q == EDIT) begin
            if (toggle) begin
                // Exit cycle: pending and coincident ticks merge into a single advance.
                if (pend_q || day_tick) begin
                    day_d = day_inc(day_q);
                end
                pend_d = 1'b0;
            end else begin
                if (step_up && !step_dn) begin
                    day_d = day_inc(day_q);
                end else if (step_dn && !step_up) begin
                    day_d = day_dec(day_q);
                end
                if (day_tick) begin
                    pend_d = 1'b1;
                end
            end
        end else if (day_tick) begin
            day_d = day_inc(day_q);
        end
    end

`ifdef WEEKDAY_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLAST_C = BW'(BLINK_HALF - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          vis_q, vis_d;
    logic          restart;

    assign restart = toggle || load_ok || ((mode_q == EDIT) && (step_up || step_dn));

    always_comb begin
        bcnt_d    = bcnt_q;
        vis_d     = vis_q;
        letters_d = day_letters(day_d);
        if (mode_d == RUN || restart) begin
            bcnt_d = '0;
            vis_d  = 1'b1;
        end else if (bcnt_q == BLAST_C) begin
            bcnt_d = '0;
            vis_d  = !vis_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end
        if (!vis_d) begin
            letters_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q <= '0;
            vis_q  <= 1'b1;
        end else begin
            bcnt_q <= bcnt_d;
            vis_q  <= vis_d;
        end
    end
`else
    always_comb begin
        letters_d = day_letters(day_d);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= RUN;
            day_q     <= RST_DAY;
            pend_q    <= 1'b0;
            start_q   <= 1'b0;
            letters_q <= day_letters(RST_DAY);
        end else begin
            mode_q    <= mode_d;
            day_q     <= day_d;
            pend_q    <= pend_d;
            start_q   <= start;
            letters_q <= letters_d;
        end
    end

    assign cur_day   = day_q;
    assign edit_mode = (mode_q == EDIT);
    assign letter0   = letters_q[3];
    assign letter1   = letters_q[2];
    assign letter2   = letters_q[1];
    assign letter3   = letters_q[0];

endmodule
